snake_timing_display: RTL and testbench

Clock-generation and score-display block for the snake game top level. It derives a programmable-rate game tick (CLK_div) and a fixed 1 kHz refresh clock (CLK_div1000HZ) from the board clock. It time-multiplexes the two-digit BCD score onto a shared seven-segment bus with digit-select COM, and decodes the selected digit to segment patterns.

---
 rtl/snake_timing_display_if.sv | 24 ++
 rtl/snake_timing_display.sv | 101 ++++++++++
 tb/tb_snake_timing_display.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/snake_timing_display_if.sv
// Bundle of the snake display/tick block's data-side signals.
// The slave modport is the block itself; the master modport is whoever drives speed and score.
interface snake_timing_display_if #(
    parameter int unsigned CNT_W = 32
);
    logic [CNT_W-1:0] speed_control;
    logic [3:0]       score;
    logic [3:0]       tens_score;
    logic             CLK_div;
    logic             CLK_div1000HZ;
    logic [3:0]       bcd_out;
    logic [1:0]       COM;
    logic [7:0]       SEG;

    modport master (
        output speed_control, score, tens_score,
        input  CLK_div, CLK_div1000HZ, bcd_out, COM, SEG
    );

    modport slave (
        input  speed_control, score, tens_score,
        output CLK_div, CLK_div1000HZ, bcd_out, COM, SEG
    );
endinterface

// File: rtl/snake_timing_display.sv
// Game-tick and 1 kHz refresh dividers plus two-digit seven-segment multiplexer.
// Digit-select states:  DIG_ONES | COM=10, ones digit lit  ;  DIG_TENS | COM=01, tens digit lit
module snake_timing_display #(
    parameter int unsigned REFRESH_HALF = 25000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    snake_timing_display_if.slave   bus
);
    typedef enum logic {DIG_ONES, DIG_TENS} dig_e;

    localparam logic [CNT_W-1:0] REF_TC = CNT_W'(REFRESH_HALF - 32'd1);

    logic [CNT_W-1:0] game_cnt_q, game_cnt_d, game_n;
    logic             game_clk_q, game_clk_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_clk_q, ref_clk_d;
    logic             ref_rise;
    dig_e             dig_q, dig_d;
    logic [3:0]       bcd_q, bcd_d;

    // A zero half-period behaves as one so the tick never stalls.
    always_comb begin
        game_n     = (bus.speed_control == '0) ? CNT_W'(1) : bus.speed_control;
        game_cnt_d = game_cnt_q + CNT_W'(1);
        game_clk_d = game_clk_q;
        if (game_cnt_q >= game_n - CNT_W'(1)) begin
            game_cnt_d = '0;
            game_clk_d = ~game_clk_q;
        end
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q + CNT_W'(1);
        ref_clk_d = ref_clk_q;
        ref_rise  = 1'b0;
        if (ref_cnt_q >= REF_TC) begin
            ref_cnt_d = '0;
            ref_clk_d = ~ref_clk_q;
            ref_rise  = ~ref_clk_q;
        end
    end

    // Score is sampled only on the refresh rising edge that switches digits.
    always_comb begin
        dig_d = dig_q;
        bcd_d = bcd_q;
        if (ref_rise) begin
            case (dig_q)
                DIG_ONES: begin
                    dig_d = DIG_TENS;
                    bcd_d = bus.tens_score;
                end
                DIG_TENS: begin
                    dig_d = DIG_ONES;
                    bcd_d = bus.score;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            game_cnt_q <= '0;
            game_clk_q <= 1'b0;
            ref_cnt_q  <= '0;
            ref_clk_q  <= 1'b0;
            dig_q      <= DIG_ONES;
            bcd_q      <= 4'd0;
        end else begin
            game_cnt_q <= game_cnt_d;
            game_clk_q <= game_clk_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_clk_q  <= ref_clk_d;
            dig_q      <= dig_d;
            bcd_q      <= bcd_d;
        end
    end

    always_comb begin
        case (bcd_q)
            4'd0:    bus.SEG = 8'hC0;
            4'd1:    bus.SEG = 8'hF9;
            4'd2:    bus.SEG = 8'hA4;
            4'd3:    bus.SEG = 8'hB0;
            4'd4:    bus.SEG = 8'h99;
            4'd5:    bus.SEG = 8'h92;
            4'd6:    bus.SEG = 8'h82;
            4'd7:    bus.SEG = 8'hF8;
            4'd8:    bus.SEG = 8'h80;
            4'd9:    bus.SEG = 8'h90;
            default: bus.SEG = 8'hFF;
        endcase
    end

    assign bus.COM           = (dig_q == DIG_TENS) ? 2'b01 : 2'b10;
    assign bus.bcd_out       = bcd_q;
    assign bus.CLK_div       = game_clk_q;
    assign bus.CLK_div1000HZ = ref_clk_q;
endmodule

// File: tb/tb_snake_timing_display.sv
// Bench for snake_timing_display: a reference model predicts output events into a
// scoreboard queue, and a monitor on the falling edge pops and compares them.
module tb_snake_timing_display;
    localparam int unsigned RH = 4;
    localparam int unsigned CW = 32;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    snake_timing_display_if #(.CNT_W(CW)) bus_if();

    snake_timing_display #(.REFRESH_HALF(RH), .CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    string kind_name [3] = '{"clk_div", "clk_1k", "digit"};

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    ev_t q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: half-period counted as edges since the last toggle.
    longint unsigned g_since = 0, r_since = 0, n_eff;
    logic            g_lvl = 1'b0, r_lvl = 1'b0, m_tens = 1'b0;
    logic [3:0]      m_bcd;
    logic [1:0]      m_com;

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            g_since = 0; r_since = 0; g_lvl = 1'b0; r_lvl = 1'b0; m_tens = 1'b0;
        end else begin
            n_eff = (bus_if.speed_control == 0) ? 1 : longint'(bus_if.speed_control);
            if (g_since + 1 >= n_eff) begin
                g_since = 0;
                g_lvl   = ~g_lvl;
                q.push_back('{cyc, 0, {15'd0, g_lvl}});
            end else g_since++;
            if (r_since + 1 >= RH) begin
                r_since = 0;
                r_lvl   = ~r_lvl;
                q.push_back('{cyc, 1, {15'd0, r_lvl}});
                if (r_lvl) begin
                    m_tens = ~m_tens;
                    m_com  = m_tens ? 2'b01 : 2'b10;
                    m_bcd  = m_tens ? bus_if.tens_score : bus_if.score;
                    q.push_back('{cyc, 2, {2'b00, m_com, m_bcd, seg_tab[m_bcd]}});
                end
            end else r_since++;
        end
    end

    logic [15:0] prev [3];
    logic [15:0] cur  [3];
    bit          seen [3];
    ev_t         e;

    always @(negedge CLK) begin
        cur[0] = {15'd0, bus_if.CLK_div};
        cur[1] = {15'd0, bus_if.CLK_div1000HZ};
        cur[2] = {2'b00, bus_if.COM, bus_if.bcd_out, bus_if.SEG};
        if (!RST) begin
            seen = '{default: 1'b0};
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check("event_cycle", e.cyc, cyc);
                check(kind_name[e.kind], {16'd0, cur[e.kind]}, {16'd0, e.val});
                seen[e.kind] = 1'b1;
            end
            for (int k = 0; k < 3; k++)
                if (!seen[k]) check({kind_name[k], "_stable"}, {16'd0, cur[k]}, {16'd0, prev[k]});
            check("com_legal", 32'(bus_if.COM == 2'b01 || bus_if.COM == 2'b10), 32'd1);
        end
        prev = cur;
    end

    task automatic run(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #2 RST = 1'b1;
        q.delete();
        #1;
        check("rst_clk_div", 32'(bus_if.CLK_div), 32'd0);
        check("rst_clk_1k",  32'(bus_if.CLK_div1000HZ), 32'd0);
        check("rst_com",     32'(bus_if.COM), 32'h2);
        check("rst_bcd",     32'(bus_if.bcd_out), 32'd0);
        check("rst_seg",     32'(bus_if.SEG), 32'hC0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
    endtask

    initial begin
        bit found;
        bus_if.speed_control = 32'd3;
        bus_if.score         = 4'd7;
        bus_if.tens_score    = 4'd2;

        pulse_reset();
        run(30);

        // Lower the rate while the game counter sits at 4.
        bus_if.speed_control = 32'd5;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #2;
            if (g_since == 4) begin
                found = 1'b1;
                break;
            end
        end
        check("rate_wait", 32'(found), 32'd1);
        bus_if.speed_control = 32'd2;
        run(20);

        bus_if.speed_control = 32'd0;
        run(10);

        bus_if.speed_control = 32'd3;
        run(7);
        pulse_reset();
        run(25);

        for (int v = 0; v < 16; v++) begin
            bus_if.score      = 4'(v);
            bus_if.tens_score = 4'(v);
            run(2 * RH + 1);
            check("sweep_bcd", 32'(bus_if.bcd_out), 32'(v));
            check("sweep_seg", 32'(bus_if.SEG), 32'(seg_tab[v]));
        end

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15, 0) == 0) bus_if.speed_control = 32'($urandom_range(7, 0));
            if ($urandom_range(7, 0) == 0) begin
                bus_if.score      = 4'($urandom_range(15, 0));
                bus_if.tens_score = 4'($urandom_range(15, 0));
            end
            if ($urandom_range(499, 0) == 0) pulse_reset();
            else run(1);
        end

        @(negedge CLK);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
